// File: rtl/xgmii_rx_frame_monitor_pkg.sv
// Shared definitions for the XGMII receive frame monitor.
// Holds the XGMII character codes, the fault ordered-set codes, the FSM
// and fault-type enums, and small helpers used by the top and the fault
// detector.
package xgmii_rx_frame_monitor_pkg;

    // XGMII control character codes
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    // Fault codes carried in the last data lane of a sequence ordered set
    localparam logic [7:0] FAULT_LF = 8'h01;
    localparam logic [7:0] FAULT_RF = 8'h02;

    // Bytes after START that belong to preamble/SFD and are not reported
    localparam logic [15:0] PREAMBLE_LEN = 16'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        FLT_NONE   = 2'd0,
        FLT_LOCAL  = 2'd1,
        FLT_REMOTE = 2'd2
    } fault_type_e;

    // Decode one 4-lane column as a link-fault ordered set.
    function automatic fault_type_e decode_os(input logic [31:0] d, input logic [3:0] c);
        fault_type_e t;
        t = FLT_NONE;
        if (c == 4'b0001 && d[7:0] == XGMII_SEQ && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == FAULT_LF)
                t = FLT_LOCAL;
            else if (d[31:24] == FAULT_RF)
                t = FLT_REMOTE;
        end
        return t;
    endfunction

    // 16-bit byte count that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/xgmii_rx_frame_monitor_fault_detect.sv
// Link-fault ordered-set detector.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   rxd[63:0], rxc[7:0] - XGMII word (two 4-lane columns)
//   enable              - high when the PHY has block lock; low holds all state
//   stat_local_fault    - four local-fault sets seen without a long gap
//   stat_remote_fault   - four remote-fault sets seen without a long gap
module xgmii_fault_detect
    import xgmii_rx_frame_monitor_pkg::*;
#(
    parameter int FAULT_WINDOW = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rxd,
    input  logic [7:0]  rxc,
    input  logic        enable,
    output logic        stat_local_fault,
    output logic        stat_remote_fault
);

    localparam int CW = $clog2(FAULT_WINDOW + 1);
    localparam logic [CW-1:0] WIN = CW'(FAULT_WINDOW);

    fault_type_e   r_type;
    logic [2:0]    r_cnt;
    logic [CW-1:0] r_cols;
    logic          r_lf;
    logic          r_rf;

    fault_type_e   w_os [2];
    fault_type_e   w_type;
    logic [2:0]    w_cnt;
    logic [CW-1:0] w_cols;
    logic          w_lf;
    logic          w_rf;

    assign w_os[0] = decode_os(rxd[31:0],  rxc[3:0]);
    assign w_os[1] = decode_os(rxd[63:32], rxc[7:4]);

    // Columns are processed in wire order so two sets in one word count twice.
    always_comb begin
        w_type = r_type;
        w_cnt  = r_cnt;
        w_cols = r_cols;
        w_lf   = r_lf;
        w_rf   = r_rf;
        for (int c = 0; c < 2; c++) begin
            if (w_os[c] != FLT_NONE) begin
                if (w_os[c] == w_type) begin
                    if (w_cnt != 3'd4)
                        w_cnt = w_cnt + 3'd1;
                end else begin
                    // A different fault type drops whatever was asserted.
                    w_type = w_os[c];
                    w_cnt  = 3'd1;
                    w_lf   = 1'b0;
                    w_rf   = 1'b0;
                end
                w_cols = '0;
                if (w_cnt == 3'd4) begin
                    w_lf = (w_os[c] == FLT_LOCAL);
                    w_rf = (w_os[c] == FLT_REMOTE);
                end
            end else begin
                if (w_cols != WIN)
                    w_cols = w_cols + 1'b1;
                if (w_cols == WIN) begin
                    w_type = FLT_NONE;
                    w_cnt  = 3'd0;
                    w_lf   = 1'b0;
                    w_rf   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_type <= FLT_NONE;
            r_cnt  <= 3'd0;
            r_cols <= '0;
            r_lf   <= 1'b0;
            r_rf   <= 1'b0;
        end else if (enable) begin
            r_type <= w_type;
            r_cnt  <= w_cnt;
            r_cols <= w_cols;
            r_lf   <= w_lf;
            r_rf   <= w_rf;
        end
    end

    assign stat_local_fault  = r_lf;
    assign stat_remote_fault = r_rf;

endmodule

// File: rtl/xgmii_rx_frame_monitor.sv
// Passive XGMII receive frame monitor.
// Delineates frames on a 64-bit XGMII bus, reports per-frame length and
// malformed status, keeps saturating good/bad frame counters and reports
// local/remote link fault status.
// Ports:
//   clk, rst              - rx clock, asynchronous active-high reset
//   xgmii_rxd, xgmii_rxc  - XGMII data/control, lane i = bits [8i+7:8i]
//   rx_block_lock         - PHY block lock; low forces the input to IDLE
//   clear_stats           - synchronous clear of both frame counters
//   frame_done            - one-cycle end-of-frame strobe
//   frame_len, frame_bad  - length (excl. preamble/SFD) and malformed flag
//   frame_count           - saturating good-frame count
//   bad_frame_count       - saturating bad-frame count
//   stat_local_fault, stat_remote_fault - link fault status
// Handshake: frame_done is a valid-only strobe with no ready/backpressure;
// frame_len and frame_bad are meaningful only in the cycle frame_done is high.
module xgmii_rx_frame_monitor
    import xgmii_rx_frame_monitor_pkg::*;
#(
    parameter int MIN_LEN      = 64,
    parameter int MAX_LEN      = 1518,
    parameter int CNT_WIDTH    = 32,
    parameter int FAULT_WINDOW = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 rx_block_lock,
    input  logic                 clear_stats,
    output logic                 frame_done,
    output logic [15:0]          frame_len,
    output logic                 frame_bad,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] bad_frame_count,
    output logic                 stat_local_fault,
    output logic                 stat_remote_fault
);

    rx_state_e r_state;
    rx_state_e w_next_state;

    logic [15:0] r_raw;          // bytes since START, preamble included
    logic        r_bad;
    logic        r_done;
    logic [15:0] r_len;
    logic        r_frame_bad;
    logic [CNT_WIDTH-1:0] r_good_cnt;
    logic [CNT_WIDTH-1:0] r_bad_cnt;

    logic [63:0] w_rxd;
    logic [7:0]  w_rxc;
    logic [7:0]  w_is_term;
    logic        w_start0;
    logic        w_start4;
    logic        w_start4_first;
    logic        w_term_found;
    logic [3:0]  w_term_idx;
    logic        w_ctrl_before_term;

    logic        w_end;
    logic [15:0] w_end_raw;
    logic        w_end_bad;
    logic [15:0] w_raw_nxt;
    logic        w_bad_nxt;
    logic [15:0] w_end_len;
    logic        w_end_bad_all;

    // Without block lock the word is meaningless; present it as all IDLE.
    assign w_rxd = rx_block_lock ? xgmii_rxd : {8{XGMII_IDLE}};
    assign w_rxc = rx_block_lock ? xgmii_rxc : 8'hFF;

    assign w_start0 = w_rxc[0] && (w_rxd[7:0]   == XGMII_START);
    assign w_start4 = w_rxc[4] && (w_rxd[39:32] == XGMII_START);
    // A lane-4 START only restarts the frame if no TERM precedes it.
    assign w_start4_first = w_start4 && (w_term_idx > 4'd4);

    always_comb begin
        w_term_found = 1'b0;
        w_term_idx   = 4'd8;
        for (int i = 0; i < 8; i++)
            w_is_term[i] = w_rxc[i] && (w_rxd[8*i +: 8] == XGMII_TERM);
        for (int i = 7; i >= 0; i--) begin
            if (w_is_term[i]) begin
                w_term_found = 1'b1;
                w_term_idx   = 4'(i);
            end
        end
        w_ctrl_before_term = 1'b0;
        for (int i = 0; i < 8; i++)
            if (4'(i) < w_term_idx)
                w_ctrl_before_term = w_ctrl_before_term | w_rxc[i];
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start0 || w_start4)
                    w_next_state = ST_FRAME;
            end
            ST_FRAME: begin
                if (!rx_block_lock)
                    w_next_state = ST_IDLE;
                else if (w_start0 || w_start4_first)
                    w_next_state = ST_FRAME;
                else if (w_term_found)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM: outputs (frame end event and running count updates)
    always_comb begin
        w_end     = 1'b0;
        w_end_raw = r_raw;
        w_end_bad = r_bad;
        w_raw_nxt = r_raw;
        w_bad_nxt = r_bad;
        case (r_state)
            ST_IDLE: begin
                if (w_start0) begin
                    w_raw_nxt = 16'd7;
                    w_bad_nxt = |w_rxc[7:1];
                end else if (w_start4) begin
                    w_raw_nxt = 16'd3;
                    w_bad_nxt = |w_rxc[7:5];
                end
            end
            ST_FRAME: begin
                if (!rx_block_lock) begin
                    w_end     = 1'b1;
                    w_end_bad = 1'b1;
                end else if (w_start0) begin
                    w_end     = 1'b1;
                    w_end_bad = 1'b1;
                    w_raw_nxt = 16'd7;
                    w_bad_nxt = |w_rxc[7:1];
                end else if (w_start4_first) begin
                    // Lanes 0-3 still belong to the abandoned frame.
                    w_end     = 1'b1;
                    w_end_raw = sat_add16(r_raw, 4'd4);
                    w_end_bad = 1'b1;
                    w_raw_nxt = 16'd3;
                    w_bad_nxt = |w_rxc[7:5];
                end else begin
                    w_raw_nxt = sat_add16(r_raw, w_term_idx);
                    w_bad_nxt = r_bad | w_ctrl_before_term;
                    if (w_term_found) begin
                        w_end     = 1'b1;
                        w_end_raw = w_raw_nxt;
                        w_end_bad = w_bad_nxt;
                    end
                end
            end
            default: ;
        endcase
    end

    // A frame that never got through its preamble reports length 0.
    always_comb begin
        w_end_len     = (w_end_raw < PREAMBLE_LEN) ? 16'd0 : (w_end_raw - PREAMBLE_LEN);
        w_end_bad_all = w_end_bad || (w_end_raw < PREAMBLE_LEN) ||
                        (w_end_len < 16'(MIN_LEN)) || (w_end_len > 16'(MAX_LEN));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw       <= 16'd0;
            r_bad       <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= 16'd0;
            r_frame_bad <= 1'b0;
        end else begin
            r_raw       <= w_raw_nxt;
            r_bad       <= w_bad_nxt;
            r_done      <= w_end;
            r_len       <= w_end ? w_end_len : 16'd0;
            r_frame_bad <= w_end ? w_end_bad_all : 1'b0;
        end
    end

    // Statistics: clear has priority over a coincident frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (clear_stats) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else if (r_done) begin
            if (r_frame_bad) begin
                if (r_bad_cnt != '1)
                    r_bad_cnt <= r_bad_cnt + 1'b1;
            end else begin
                if (r_good_cnt != '1)
                    r_good_cnt <= r_good_cnt + 1'b1;
            end
        end
    end

    xgmii_fault_detect #(
        .FAULT_WINDOW (FAULT_WINDOW)
    ) u_fault (
        .clk               (clk),
        .rst               (rst),
        .rxd               (xgmii_rxd),
        .rxc               (xgmii_rxc),
        .enable            (rx_block_lock),
        .stat_local_fault  (stat_local_fault),
        .stat_remote_fault (stat_remote_fault)
    );

    assign frame_done      = r_done;
    assign frame_len       = r_len;
    assign frame_bad       = r_frame_bad;
    assign frame_count     = r_good_cnt;
    assign bad_frame_count = r_bad_cnt;

endmodule

// File: tb/tb_xgmii_rx_frame_monitor.sv
module tb_xgmii_rx_frame_monitor;

    localparam int CW = 4;

    localparam logic [7:0] C_IDLE  = 8'h07;
    localparam logic [7:0] C_START = 8'hFB;
    localparam logic [7:0] C_TERM  = 8'hFD;
    localparam logic [7:0] C_ERROR = 8'hFE;
    localparam logic [7:0] C_SEQ   = 8'h9C;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0]   xgmii_rxd;
    logic [7:0]    xgmii_rxc;
    logic          rx_block_lock;
    logic          clear_stats;
    logic          frame_done;
    logic [15:0]   frame_len;
    logic          frame_bad;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] bad_frame_count;
    logic          stat_local_fault;
    logic          stat_remote_fault;

    xgmii_rx_frame_monitor #(
        .MIN_LEN      (64),
        .MAX_LEN      (1518),
        .CNT_WIDTH    (CW),
        .FAULT_WINDOW (128)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .xgmii_rxd         (xgmii_rxd),
        .xgmii_rxc         (xgmii_rxc),
        .rx_block_lock     (rx_block_lock),
        .clear_stats       (clear_stats),
        .frame_done        (frame_done),
        .frame_len         (frame_len),
        .frame_bad         (frame_bad),
        .frame_count       (frame_count),
        .bad_frame_count   (bad_frame_count),
        .stat_local_fault  (stat_local_fault),
        .stat_remote_fault (stat_remote_fault)
    );

    // scoreboard state
    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_q[$];     // {bad, len}
    logic [8:0]  lane_q[$];    // {ctrl, byte}
    int exp_good = 0;
    int exp_badc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops one expectation per frame_done strobe
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && frame_done !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_frame_done: got len %0d bad %0d expected no frame", frame_len, frame_bad);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    check("frame_len", 32'(frame_len), 32'(e[15:0]));
                    check("frame_bad", 32'(frame_bad), 32'(e[16]));
                end
            end
        end
    end

    // driver tasks
    task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
        xgmii_rxd = d;
        xgmii_rxc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_words(input int n);
        repeat (n) drive_word({8{C_IDLE}}, 8'hFF);
    endtask

    task automatic put(input logic ctrl, input logic [7:0] b);
        lane_q.push_back({ctrl, b});
    endtask

    task automatic put_data(input int n);
        repeat (n) put(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic start_frame(input int lane);
        if (lane == 4) repeat (4) put(1'b1, C_IDLE);
        put(1'b1, C_START);
        repeat (6) put(1'b0, 8'h55);
        put(1'b0, 8'hD5);
    endtask

    task automatic flush();
        while (lane_q.size() >= 8) begin
            logic [63:0] d;
            logic [7:0]  c;
            for (int i = 0; i < 8; i++) begin
                logic [8:0] l;
                l = lane_q.pop_front();
                d[8*i +: 8] = l[7:0];
                c[i] = l[8];
            end
            drive_word(d, c);
        end
    endtask

    task automatic end_frame();
        put(1'b1, C_TERM);
        while (lane_q.size() % 8 != 0) put(1'b1, C_IDLE);
        flush();
    endtask

    task automatic expect_frame(input int len, input bit bad, input bit counted);
        exp_q.push_back({bad, 16'(len)});
        if (counted) begin
            if (bad) exp_badc = (exp_badc == 15) ? 15 : exp_badc + 1;
            else     exp_good = (exp_good == 15) ? 15 : exp_good + 1;
        end
    endtask

    task automatic frame(input int lane, input int n, input bit bad);
        start_frame(lane);
        put_data(n);
        expect_frame(n, bad, 1'b1);
        end_frame();
        idle_words(2);
    endtask

    task automatic check_counters(input string tag);
        idle_words(2);
        check({tag, "_frame_count"}, 32'(frame_count), 32'(exp_good));
        check({tag, "_bad_frame_count"}, 32'(bad_frame_count), 32'(exp_badc));
    endtask

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    localparam logic [63:0] LF_WORD  = {C_IDLE, C_IDLE, C_IDLE, C_IDLE, 8'h01, 8'h00, 8'h00, C_SEQ};
    localparam logic [63:0] RF_WORD  = {C_IDLE, C_IDLE, C_IDLE, C_IDLE, 8'h02, 8'h00, 8'h00, C_SEQ};
    localparam logic [63:0] RF2_WORD = {8'h02, 8'h00, 8'h00, C_SEQ, 8'h02, 8'h00, 8'h00, C_SEQ};

    initial begin
        rst = 1'b1;
        rx_block_lock = 1'b1;
        clear_stats = 1'b0;
        xgmii_rxd = {8{C_IDLE}};
        xgmii_rxc = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_frame_done", 32'(frame_done), 0);
        check("reset_frame_len", 32'(frame_len), 0);
        check("reset_frame_count", 32'(frame_count), 0);
        check("reset_bad_count", 32'(bad_frame_count), 0);
        check("reset_lf", 32'(stat_local_fault), 0);
        check("reset_rf", 32'(stat_remote_fault), 0);
        rst = 1'b0;
        idle_words(2);

        // basic 64-byte frame
        frame(0, 64, 1'b0);
        check_counters("basic");

        // lane-4 start and length limits
        frame(4, 1514, 1'b0);
        frame(0, 60, 1'b1);
        frame(0, 63, 1'b1);
        frame(4, 1518, 1'b0);
        frame(0, 1519, 1'b1);
        check_counters("limits");

        // ERROR character at lane 3 of a 100-byte frame
        start_frame(0);
        put_data(43);
        put(1'b1, C_ERROR);
        put_data(56);
        expect_frame(100, 1'b1, 1'b1);
        end_frame();
        idle_words(2);

        // START before TERM: 24 bytes cut short, then a normal frame
        start_frame(0);
        put_data(24);
        expect_frame(24, 1'b1, 1'b1);
        flush();
        frame(0, 64, 1'b0);
        check_counters("restart");

        // preamble cut short by TERM
        start_frame(0);
        expect_frame(0, 1'b1, 1'b1);
        end_frame();
        idle_words(2);
        repeat (4) put(1'b1, C_IDLE);
        put(1'b1, C_START);
        repeat (3) put(1'b0, 8'h55);
        expect_frame(0, 1'b1, 1'b1);
        end_frame();
        check_counters("short");

        // lock loss mid-frame, later TERM must not produce a pulse
        start_frame(0);
        put_data(32);
        flush();
        expect_frame(32, 1'b1, 1'b1);
        rx_block_lock = 1'b0;
        repeat (3) drive_word({$urandom, $urandom}, 8'h00);
        rx_block_lock = 1'b1;
        put_data(12);
        end_frame();
        idle_words(2);
        check_counters("lock");

        // fault detection
        for (int k = 1; k <= 4; k++) begin
            drive_word(LF_WORD, 8'hF1);
            check($sformatf("lf_after_%0d", k), 32'(stat_local_fault), (k == 4) ? 1 : 0);
            check($sformatf("rf_during_lf_%0d", k), 32'(stat_remote_fault), 0);
        end
        drive_word(RF_WORD, 8'hF1);
        check("lf_cleared_by_rf", 32'(stat_local_fault), 0);
        check("rf_after_one", 32'(stat_remote_fault), 0);
        idle_words(64);
        check("lf_after_window", 32'(stat_local_fault), 0);
        drive_word(RF2_WORD, 8'h11);
        check("rf_after_two_sets", 32'(stat_remote_fault), 0);
        drive_word(RF2_WORD, 8'h11);
        check("rf_after_four_sets", 32'(stat_remote_fault), 1);
        check("lf_while_rf", 32'(stat_local_fault), 0);
        idle_words(63);
        check("rf_window_minus_2", 32'(stat_remote_fault), 1);
        idle_words(1);
        check("rf_window_expired", 32'(stat_remote_fault), 0);

        // clear_stats coincident with a good frame_done
        start_frame(0);
        put_data(64);
        expect_frame(64, 1'b0, 1'b0);
        end_frame();
        clear_stats = 1'b1;
        idle_words(1);
        clear_stats = 1'b0;
        exp_good = 0;
        exp_badc = 0;
        check_counters("clear");

        // saturation of the 4-bit good counter
        repeat (17) frame(0, 64, 1'b0);
        check_counters("saturate");

        // reset mid-frame: no frame_done, counters back to zero
        start_frame(0);
        put_data(16);
        flush();
        rst = 1'b1;
        #2;
        check("rst_mid_done", 32'(frame_done), 0);
        check("rst_mid_count", 32'(frame_count), 0);
        idle_words(1);
        rst = 1'b0;
        exp_good = 0;
        exp_badc = 0;
        put_data(8);
        end_frame();
        idle_words(2);
        check_counters("rst_mid");

        idle_words(3);
        check("exp_q_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xgmii_rx_frame_monitor.md
Name: xgmii_rx_frame_monitor

Overview:
- Passive receive-side monitor on the 64-bit XGMII bus coming out of a 10G PHY wrapper (e.g. sfp_1_rxd/sfp_1_rxc in the rx clock domain).
- It is the counterpart of the transmit-path XGMII driver: it delineates frames from start/terminate characters, measures frame length and flags malformed frames.
- It keeps saturating frame and bad-frame statistics and decodes local/remote link-fault ordered sets for LED and status use.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes (post-SFD through FCS).
- MAX_LEN, 1518, maximum legal frame length in bytes.
- CNT_WIDTH, 32, width of the statistics counters.
- FAULT_WINDOW, 128, columns without a fault ordered set before fault status clears.

Ports:
- clk  in  1  rx clock (PHY rx_clk, 156.25 MHz).
- rst  in  1  asynchronous, active-high reset.
- xgmii_rxd  in  64  XGMII data; lane i = bits [8i+7:8i].
- xgmii_rxc  in  8  XGMII control; bit i=1 means lane i is a control character.
- rx_block_lock  in  1  PHY block lock; low means input is invalid.
- clear_stats  in  1  synchronous clear of both counters.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_len  out  16  byte count of the ended frame; valid with frame_done.
- frame_bad  out  1  ended frame malformed; valid with frame_done.
- frame_count  out  CNT_WIDTH  saturating count of good frames.
- bad_frame_count  out  CNT_WIDTH  saturating count of bad frames.
- stat_local_fault  out  1  local fault detected.
- stat_remote_fault  out  1  remote fault detected.

Behaviour:
- Reset: all outputs 0; state IDLE; counters, fault counts and column counters 0.
- XGMII characters: IDLE 0x07, START 0xFB, TERM 0xFD, ERROR 0xFE, SEQ 0x9C.
- START is legal only in lane 0 or lane 4. START in any other lane while IDLE is ignored.
- FSM states: IDLE and FRAME.
- IDLE -> FRAME on START in lane 0 or 4.
  - Byte counting starts with the lanes after START. The first 7 counted bytes (preamble/SFD) are discarded, so frame_len excludes them.
  - Example: START lane 0, 8 full data words, TERM lane 0 gives frame_len = 64 - 7 + 7 = 64.
- FRAME: each word adds the number of data lanes preceding the first TERM, or 8 if the word has no TERM.
  - The internal count saturates at 16'hFFFF.
- FRAME -> IDLE on TERM in any lane. Lanes after TERM are ignored.
- bad is set when any of these occurs within a frame:
  - ERROR character in any lane;
  - any control character other than TERM;
  - final length < MIN_LEN or > MAX_LEN;
  - fewer than 7 bytes before TERM (frame_len reported as 0).
- frame_done, frame_len and frame_bad are registered one cycle after the word carrying TERM.
- START received in FRAME (new lane 0/4 START before TERM):
  - current frame ends with frame_done and frame_bad=1, length as counted so far;
  - a new frame starts from that START in the same cycle.
- rx_block_lock low:
  - every word is treated as IDLE;
  - in FRAME, the frame ends next cycle with frame_bad=1;
  - fault detection counters are held and status is unchanged.
- Counters: on frame_done, frame_count increments if good and bad_frame_count if bad. Both saturate at all-ones.
  - clear_stats zeroes both counters. If clear_stats coincides with frame_done, the clear wins and that frame is not counted.
- Fault detection (Clause 46 style):
  - An ordered set is SEQ in lane 0 or 4 with rxc=1 on that lane and data lanes +1..+3 = 00,00,01 (local fault) or 00,00,02 (remote fault).
  - Each word holds 2 columns; a word may carry up to 2 ordered sets.
  - A per-type count increments per ordered set. A different fault type restarts the count at 1 for the new type.
  - Status for a type asserts when its count reaches 4 with no gap of FAULT_WINDOW columns or more between ordered sets.
  - The column counter resets on every ordered set. Reaching FAULT_WINDOW columns without an ordered set clears both statuses and counts.
  - stat_local_fault and stat_remote_fault are never both 1. A newly asserted type deasserts the other.
- Reset mid-frame: frame is discarded; no frame_done.

Decomposition:
- Shared header `xgmii_defs.vh`: localparams for the XGMII character codes (0x07, 0xFB, 0xFD, 0xFE, 0x9C) and fault codes LF=0x01, RF=0x02.
- Sub-module `xgmii_fault_detect`: inputs clk, rst, rxd, rxc, enable; outputs the two fault status bits. It owns the ordered-set decode and the column window.

Test Plan:
- Frame length: START lane 0, 7 preamble bytes, 64 data bytes, TERM lane 0 -> one frame_done, frame_len=64, frame_bad=0, frame_count=1.
- Lane 4 start: START lane 4, 1514 data bytes, TERM -> frame_len=1514, good. Then a 60-byte frame -> frame_bad=1, bad_frame_count=1.
- Error in frame: 0xFE at lane 3 mid-frame of a 100-byte frame -> frame_len=100, frame_bad=1. Second START before TERM -> bad pulse, then the new frame is counted normally.
- Lock loss: rx_block_lock dropped mid-frame -> frame_done next cycle with frame_bad=1. A later TERM produces no extra pulse.
- Fault assert/clear: 4 words each with a local fault set in lane 0 -> stat_local_fault=1 after the 4th. One remote set -> local cleared, remote count=1. 64 idle words -> all fault status 0.
- Clear and saturation: clear_stats coincident with a good frame_done -> frame_count=0. With CNT_WIDTH=4, 17 good frames -> frame_count=15.
